// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium session sequencer: FSM encoding and word geometry.
package trivium_pkg;

    localparam int unsigned KEY_WORDS = 3;
    localparam int unsigned IV_WORDS  = 3;
    localparam int unsigned CORE_DW   = 32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_KEY,
        ST_LD_IV,
        ST_INIT_REQ,
        ST_INIT_WAIT,
        ST_FETCH,
        ST_PROC_REQ,
        ST_PROC_WAIT,
        ST_OUT
    } state_t;

    // States that wait on the core handshake and are therefore guarded by the timeout.
    function automatic logic is_timed(input state_t s);
        return (s == ST_INIT_REQ) || (s == ST_INIT_WAIT) ||
               (s == ST_PROC_REQ) || (s == ST_PROC_WAIT);
    endfunction

endpackage

// File: rtl/trivium_hs_timer.sv
// Handshake watchdog: clear/enable cycle counter whose terminal flag marks the
// TMO_MAX-th enabled cycle since the last clear.
module trivium_hs_timer #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 200
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_MAX - 1);

    logic [TMO_W-1:0] cnt_q;

    assign expired = en && (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/trivium_stream_ctrl.sv
// Session sequencer for trivium_top: loads key/IV, runs init, then streams
// a programmed number of words through the core with a per-phase watchdog.
module trivium_stream_ctrl
    import trivium_pkg::*;
#(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 200
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [79:0]        key_i,
    input  logic [79:0]        iv_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [31:0]        s_dat_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic [31:0]        m_dat_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [31:0]        core_dat_o,
    output logic [31:0]        core_ld_dat_o,
    output logic [2:0]         core_ld_reg_a_o,
    output logic [2:0]         core_ld_reg_b_o,
    output logic               core_init_o,
    output logic               core_proc_o,
    input  logic [31:0]        core_dat_i,
    input  logic               core_busy_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int unsigned KW = KEY_WORDS * CORE_DW;
    localparam int unsigned VW = IV_WORDS * CORE_DW;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [KW-1:0]    key_q, key_d;
    logic [VW-1:0]    iv_q, iv_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    logic [31:0] cdat_d, mdat_d, ld_dat_d;
    logic [2:0]  ld_a_d, ld_b_d;
    logic        mvalid_d, sready_d, init_d, proc_d, busy_d, done_d, err_d;

    logic tmo_clr, tmo_en, tmo;

    assign tmo_en  = is_timed(state_q);
    assign tmo_clr = is_timed(state_d) && (state_d != state_q);

    trivium_hs_timer #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        key_d    = key_q;
        iv_d     = iv_q;
        rem_d    = rem_q;
        cdat_d   = core_dat_o;
        mdat_d   = m_dat_o;
        mvalid_d = m_valid_o;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !core_busy_i) begin
                    state_d = ST_LD_KEY;
                    idx_d   = '0;
                    key_d   = {{(KW-80){1'b0}}, key_i};
                    iv_d    = {{(VW-80){1'b0}}, iv_i};
                    rem_d   = len_i;
                end
            end
            ST_LD_KEY: begin
                if (idx_q == 2'(KEY_WORDS - 1)) begin
                    state_d = ST_LD_IV;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_LD_IV: begin
                if (idx_q == 2'(IV_WORDS - 1)) begin
                    state_d = ST_INIT_REQ;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_INIT_REQ: begin
                if (core_busy_i) begin
                    state_d = ST_INIT_WAIT;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_INIT_WAIT: begin
                if (!core_busy_i) begin
                    if (rem_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (tmo) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (s_valid_i) begin
                    cdat_d  = s_dat_i;
                    state_d = ST_PROC_REQ;
                end
            end
            ST_PROC_REQ: begin
                if (core_busy_i) begin
                    state_d = ST_PROC_WAIT;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_PROC_WAIT: begin
                if (!core_busy_i) begin
                    mdat_d   = core_dat_i;
                    mvalid_d = 1'b1;
                    rem_d    = rem_q - 1'b1;
                    state_d  = ST_OUT;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_OUT: begin
                if (m_ready_i) begin
                    mvalid_d = 1'b0;
                    if (rem_q != '0) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides every transition above, including a coincident completion.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            mvalid_d = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b1;
        end

        // Strobes are decoded from the next state so they register in step with it.
        ld_a_d   = '0;
        ld_b_d   = '0;
        ld_dat_d = '0;
        if (state_d == ST_LD_KEY) begin
            ld_a_d   = 3'b001 << idx_d;
            ld_dat_d = key_d[idx_d * CORE_DW +: CORE_DW];
        end else if (state_d == ST_LD_IV) begin
            ld_b_d   = 3'b001 << idx_d;
            ld_dat_d = iv_d[idx_d * CORE_DW +: CORE_DW];
        end
        init_d   = (state_d == ST_INIT_REQ);
        proc_d   = (state_d == ST_PROC_REQ);
        sready_d = (state_d == ST_FETCH);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            key_q           <= '0;
            iv_q            <= '0;
            rem_q           <= '0;
            s_ready_o       <= 1'b0;
            m_dat_o         <= '0;
            m_valid_o       <= 1'b0;
            core_dat_o      <= '0;
            core_ld_dat_o   <= '0;
            core_ld_reg_a_o <= '0;
            core_ld_reg_b_o <= '0;
            core_init_o     <= 1'b0;
            core_proc_o     <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            key_q           <= key_d;
            iv_q            <= iv_d;
            rem_q           <= rem_d;
            s_ready_o       <= sready_d;
            m_dat_o         <= mdat_d;
            m_valid_o       <= mvalid_d;
            core_dat_o      <= cdat_d;
            core_ld_dat_o   <= ld_dat_d;
            core_ld_reg_a_o <= ld_a_d;
            core_ld_reg_b_o <= ld_b_d;
            core_init_o     <= init_d;
            core_proc_o     <= proc_d;
            busy_o          <= busy_d;
            done_o          <= done_d;
            err_o           <= err_d;
        end
    end

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Bench for trivium_stream_ctrl with a behavioural stand-in core whose keystream
// is a simple function of the loaded key/IV words and the word index.
module tb_trivium_stream_ctrl;

    localparam int unsigned LEN_W    = 16;
    localparam int unsigned TMO_W    = 8;
    localparam int unsigned TMO_MAX  = 200;
    localparam int unsigned INIT_LAT = 5;
    localparam int unsigned PROC_LAT = 4;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [79:0]       key_i = '0;
    logic [79:0]       iv_i = '0;
    logic [LEN_W-1:0]  len_i = '0;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [31:0]       s_dat_i = '0;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [31:0]       m_dat_o;
    logic              m_valid_o;
    logic              m_ready_i = 1'b0;
    logic [31:0]       core_dat_o, core_ld_dat_o;
    logic [2:0]        core_ld_reg_a_o, core_ld_reg_b_o;
    logic              core_init_o, core_proc_o;
    logic [31:0]       core_dout;
    logic              core_busy;
    logic              busy_o, done_o, err_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    trivium_stream_ctrl #(
        .LEN_W   (LEN_W),
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .key_i           (key_i),
        .iv_i            (iv_i),
        .len_i           (len_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .s_dat_i         (s_dat_i),
        .s_valid_i       (s_valid_i),
        .s_ready_o       (s_ready_o),
        .m_dat_o         (m_dat_o),
        .m_valid_o       (m_valid_o),
        .m_ready_i       (m_ready_i),
        .core_dat_o      (core_dat_o),
        .core_ld_dat_o   (core_ld_dat_o),
        .core_ld_reg_a_o (core_ld_reg_a_o),
        .core_ld_reg_b_o (core_ld_reg_b_o),
        .core_init_o     (core_init_o),
        .core_proc_o     (core_proc_o),
        .core_dat_i      (core_dout),
        .core_busy_i     (core_busy),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    // Keystream word n: plaintext XOR this gives the ciphertext of word n.
    function automatic logic [31:0] ks_fn(input logic [95:0] k, input logic [95:0] v,
                                          input int unsigned n);
        logic [31:0] kw, vw;
        kw = k[32*(n%3) +: 32];
        vw = v[32*((n+1)%3) +: 32];
        return kw ^ {vw[15:0], vw[31:16]} ^ (32'(n + 1) * 32'h9E3779B9);
    endfunction

    // Stand-in core: busy one cycle after a request, fixed latencies.
    logic [95:0] ka_w = '0, kb_w = '0;
    int unsigned busy_cnt = 0;
    int unsigned nproc = 0;
    bit          core_dead = 1'b0;

    always @(posedge clk) begin
        if (rst_i) begin
            core_busy <= 1'b0;
            core_dout <= '0;
            busy_cnt  <= 0;
            nproc     <= 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (core_ld_reg_a_o[k]) ka_w[32*k +: 32] <= core_ld_dat_o;
                if (core_ld_reg_b_o[k]) kb_w[32*k +: 32] <= core_ld_dat_o;
            end
            if (core_busy) begin
                if (busy_cnt == 1) core_busy <= 1'b0;
                busy_cnt <= busy_cnt - 1;
            end else if (!core_dead && core_init_o) begin
                core_busy <= 1'b1;
                busy_cnt  <= INIT_LAT;
                nproc     <= 0;
            end else if (!core_dead && core_proc_o) begin
                core_busy <= 1'b1;
                busy_cnt  <= PROC_LAT;
                core_dout <= core_dat_o ^ ks_fn(ka_w, kb_w, nproc);
                nproc     <= nproc + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] pt [0:15];

    task automatic run_stream(input string tag, input logic [79:0] key, input logic [79:0] iv,
                              input int unsigned len, input bit slow);
        int unsigned sent, rcvd, cyc;
        bit          fin, stalled;
        logic [31:0] held, exp;
        sent = 0; rcvd = 0; cyc = 0; fin = 1'b0; stalled = 1'b0; held = '0;
        key_i = key; iv_i = iv; len_i = LEN_W'(len); start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        while (!fin && cyc < 4000) begin
            if (stalled) begin
                check($sformatf("%s_stall_valid", tag), 128'(m_valid_o), 128'(1));
                check($sformatf("%s_stall_dat", tag), 128'(m_dat_o), 128'(held));
            end
            if (done_o || err_o) begin
                fin = 1'b1;
                check($sformatf("%s_err_at_end", tag), 128'(err_o), 128'(0));
            end else begin
                s_valid_i = slow ? 1'($urandom_range(0, 1)) : 1'b1;
                s_dat_i   = (sent < len && sent < 16) ? pt[sent] : $urandom;
                if (s_ready_o && s_valid_i) sent++;
                m_ready_i = slow ? (cyc % 3 == 0) : 1'b1;
                stalled = 1'b0;
                if (m_valid_o) begin
                    if (m_ready_i) begin
                        exp = ((rcvd < 16) ? pt[rcvd] : 32'h0) ^
                              ks_fn({16'h0, key}, {16'h0, iv}, rcvd);
                        check($sformatf("%s_word%0d", tag, rcvd), 128'(m_dat_o), 128'(exp));
                        rcvd++;
                    end else begin
                        stalled = 1'b1;
                        held    = m_dat_o;
                    end
                end
                cyc++;
                @(negedge clk);
            end
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        check($sformatf("%s_completed", tag), 128'(fin), 128'(1));
        check($sformatf("%s_words_in", tag), 128'(sent), 128'(len));
        check($sformatf("%s_words_out", tag), 128'(rcvd), 128'(len));
        @(negedge clk);
        check($sformatf("%s_done_pulse", tag), 128'({done_o, busy_o}), 128'(0));
    endtask

    logic [2:0]  exp_a [6] = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0};
    logic [2:0]  exp_b [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4};
    logic [31:0] exp_d [6] = '{32'h80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    initial begin
        int unsigned n;
        bit          seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              128'({s_ready_o, m_dat_o, m_valid_o, core_dat_o, core_ld_dat_o, core_ld_reg_a_o,
                    core_ld_reg_b_o, core_init_o, core_proc_o, busy_o, done_o, err_o}), 128'(0));
        rst_i = 1'b0;
        @(negedge clk);

        // Minimum session, len=0: strobe sequence then done
        key_i = 80'h00000000000000000080; iv_i = '0; len_i = '0; start_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            check($sformatf("t1_ld_a_%0d", i), 128'(core_ld_reg_a_o), 128'(exp_a[i]));
            check($sformatf("t1_ld_b_%0d", i), 128'(core_ld_reg_b_o), 128'(exp_b[i]));
            check($sformatf("t1_ld_dat_%0d", i), 128'(core_ld_dat_o), 128'(exp_d[i]));
        end
        @(negedge clk);
        check("t1_init", 128'({core_init_o, busy_o}), 128'(2'b11));
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        check("t1_done", 128'({seen, err_o}), 128'(2'b10));
        @(negedge clk);
        check("t1_done_pulse", 128'({done_o, busy_o}), 128'(0));

        // len=4, full-rate streaming with fixed plaintexts
        pt[0] = 32'h0; pt[1] = 32'h1; pt[2] = 32'hFFFFFFFF; pt[3] = 32'hA5A5A5A5;
        run_stream("t2", {$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 4, 1'b0);

        // len=3, back-pressured output and random input valid
        for (int i = 0; i < 3; i++) pt[i] = $urandom;
        run_stream("t3", {$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 3, 1'b1);

        // Core never goes busy: timeout in INIT_REQ
        core_dead = 1'b1;
        key_i = {$urandom, $urandom, 16'($urandom)}; len_i = 16'd2; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        for (int i = 0; i < 400 && !err_o; i++) begin
            if (core_init_o) n++;
            @(negedge clk);
        end
        check("t4_err", 128'({err_o, done_o}), 128'(2'b10));
        check("t4_init_cycles", 128'(n), 128'(TMO_MAX));
        @(negedge clk);
        check("t4_idle_after", 128'({busy_o, err_o, core_init_o}), 128'(0));
        core_dead = 1'b0;

        // Abort during PROC_WAIT of the second word
        key_i = {$urandom, $urandom, 16'($urandom)}; len_i = 16'd4; start_i = 1'b1;
        s_valid_i = 1'b1; m_ready_i = 1'b1; s_dat_i = $urandom;
        @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (nproc == 2 && core_busy && !core_proc_o && busy_o) seen = 1'b1;
            else @(negedge clk);
        end
        check("t5_reached_proc_wait", 128'(seen), 128'(1));
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
        check("t5_abort_state",
              128'({core_proc_o, m_valid_o, err_o, done_o, busy_o}), 128'(5'b00100));
        @(negedge clk);
        check("t5_err_pulse", 128'(err_o), 128'(0));
        for (int i = 0; i < 20 && core_busy; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) pt[i] = $urandom;
        run_stream("t5_clean", {$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 3, 1'b0);

        // start held through loading, reset mid LD_IV
        key_i = {$urandom, $urandom, 16'($urandom)}; iv_i = {$urandom, $urandom, 16'($urandom)};
        len_i = 16'd1; start_i = 1'b1;
        @(negedge clk);
        check("t6_ld_a0", 128'(core_ld_reg_a_o), 128'(3'd1));
        @(negedge clk);
        check("t6_ld_a1", 128'(core_ld_reg_a_o), 128'(3'd2));
        @(negedge clk);
        check("t6_ld_a2", 128'(core_ld_reg_a_o), 128'(3'd4));
        @(negedge clk);
        check("t6_ld_b0", 128'({core_ld_reg_b_o, core_ld_dat_o}), 128'({3'd1, iv_i[31:0]}));
        rst_i = 1'b1;
        @(negedge clk);
        check("t6_reset_outputs",
              128'({s_ready_o, m_dat_o, m_valid_o, core_dat_o, core_ld_dat_o, core_ld_reg_a_o,
                    core_ld_reg_b_o, core_init_o, core_proc_o, busy_o, done_o, err_o}), 128'(0));
        rst_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check("t6_idle", 128'({busy_o, core_ld_reg_b_o}), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
